fb_pixel_fetch: RTL and testbench
=================================

Name: fb_pixel_fetch

Overview:
- Sits between the HDMI timing controller and port B of memory_stage.
- Converts the raster position (pixel_x, pixel_y) into framebuffer read addresses and issues reads only inside a centred image window.
- Returns one 24-bit colour per pixel, time-aligned with delayed de/hs/vs; outside the window it outputs BORDER_COLOR.
- Replaces the per-pixel multiply with an incremental row-base accumulator and compensates memory read latency.

Parameters:
- IMG_W, 300, image width in pixels.
- IMG_H, 300, image height in lines.
- X_OFF, 170, first window column (raster x).
- Y_OFF, 90, first window line (raster y).
- X_W, 10, pixel_x width.
- Y_W, 9, pixel_y width.
- ADDR_W, 17, framebuffer address width.
- RD_LATENCY, 1, cycles from rd_addr to valid rd_data (1..4).
- BORDER_COLOR, 24'h000000, colour shown outside the window.

Ports:
- clk  in  1  pixel clock, same clock as memory port B.
- rst  in  1  synchronous, active-high reset.
- pixel_x  in  X_W  raster column from the timing controller.
- pixel_y  in  Y_W  raster line from the timing controller.
- de_in  in  1  active-video flag aligned with pixel_x/pixel_y.
- hs_in  in  1  hsync aligned with pixel_x/pixel_y.
- vs_in  in  1  vsync aligned with pixel_x/pixel_y.
- rd_addr  out  ADDR_W  read address to memory port B.
- rd_en  out  1  high when rd_addr is a valid in-window read.
- rd_data  in  24  memory read data, valid RD_LATENCY cycles after rd_addr.
- color_out  out  24  pixel colour to the HDMI data path.
- de_out  out  1  de_in delayed by L cycles.
- hs_out  out  1  hs_in delayed by L cycles.
- vs_out  out  1  vs_in delayed by L cycles.
- synced  out  1  high once a frame start has been seen after reset.

Behaviour:
- Total latency L = RD_LATENCY + 2. Stage 1 registers rd_addr/rd_en. Stages 2..L-1 are the memory latency. Stage L registers color_out.
- Reset values: rd_addr=0, rd_en=0, color_out=BORDER_COLOR, de_out/hs_out/vs_out=0, synced=0, row_base=0, prev_y=0, all delay-line stages cleared.
- Window test: in_win = de_in && (X_OFF <= x < X_OFF+IMG_W) && (Y_OFF <= y < Y_OFF+IMG_H) && synced_eff, where synced_eff = synced || frame_start.
- Comparisons are unsigned, widened to X_W+1 / Y_W+1 bits so the sums cannot overflow.
- Row base: prev_y is registered every cycle; new_line = (pixel_y != prev_y).
  - On new_line with pixel_y == Y_OFF: row_base_eff = 0.
  - On new_line with Y_OFF < pixel_y < Y_OFF+IMG_H: row_base_eff = row_base + IMG_W.
  - Otherwise row_base_eff = row_base.
  - row_base <= row_base_eff each cycle.
  - The bypass is required so that X_OFF=0 works.
- Address: when in_win, rd_addr <= row_base_eff + (x - X_OFF), computed in ADDR_W bits; the maximum is IMG_W*IMG_H-1 = 89999. When not in_win, rd_addr holds its value and rd_en <= 0.
- Colour: color_out <= (win delayed to stage L) ? rd_data : BORDER_COLOR. The in_win flag travels through the same delay line as de/hs/vs.
- Sync FSM with two states:
  - UNSYNC to SYNC on frame_start (pixel_x==0 && pixel_y==0), registered into synced.
  - SYNC stays SYNC until rst.
  - While UNSYNC, no reads are issued and color_out = BORDER_COLOR; de/hs/vs still propagate normally.
- Reset mid-frame: all state is cleared, which forces UNSYNC. The accumulated row_base is untrusted until the next frame start.
- Non-monotonic y (pixel_y jumps backwards outside frame start): treat it as a new line with the rules above. No error flag is raised.
- Simultaneous frame_start and in-window pixel (window at 0,0) is served as in-window on that same cycle.

Decomposition:
- Package fb_pkg holds:
  - typedef color_t (logic [23:0]) and fb_addr_t (logic [ADDR_W-1:0]);
  - default IMG_W, IMG_H, X_OFF, Y_OFF, BORDER_COLOR;
  - constant FB_WORDS = IMG_W*IMG_H.
- Sub-module sync_delay: a parameterized-width, parameterized-depth shift register with synchronous reset. One instance carries {win, de, hs, vs} through L cycles.

Test Plan:
- Raster at x=170, y=90, de=1, synced → rd_addr=0, rd_en=1 after 1 cycle; color_out = mem[0] and de_out=1 exactly 3 cycles after input (RD_LATENCY=1).
- Step to y=91, x=170 → rd_addr=300; x=469, y=389 → rd_addr=89999. A full-frame scan checks every address equals (y-90)*300+(x-170).
- x=169 or x=470 or y=89 or y=390, or de=0 → rd_en=0, rd_addr held, color_out=24'h000000 at L.
- Assert rst at y=200 mid-frame, release → synced=0, color_out=BORDER_COLOR, no rd_en until x=0, y=0. Then the first window pixel gives rd_addr=0.
- RD_LATENCY=3 build → de_out/hs_out/vs_out and color_out lag inputs by exactly 5 cycles; memory model data appears on the correct pixel.
- X_OFF=0, Y_OFF=0 build → at x=0, y=0 rd_en=1, rd_addr=0 on the frame_start cycle; at x=0, y=1 rd_addr=300 (bypass path).

Source files
------------

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and default geometry for the framebuffer pixel fetch path
package fb_pkg;

  localparam int DEF_ADDR_W = 17;
  localparam int DEF_IMG_W  = 300;
  localparam int DEF_IMG_H  = 300;
  localparam int DEF_X_OFF  = 170;
  localparam int DEF_Y_OFF  = 90;
  localparam int FB_WORDS   = DEF_IMG_W * DEF_IMG_H;

  typedef logic [23:0]           color_t;
  typedef logic [DEF_ADDR_W-1:0] fb_addr_t;

  localparam color_t DEF_BORDER_COLOR = 24'h000000;

  typedef enum logic {
    ST_UNSYNC = 1'b0,
    ST_SYNC   = 1'b1
  } sync_state_t;

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - fixed-depth shift register with synchronous active-high clear
module sync_delay #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/fb_pixel_fetch.sv
// rtl/fb_pixel_fetch.sv - raster position to framebuffer read, latency-aligned colour with delayed syncs
module fb_pixel_fetch
  import fb_pkg::*;
#(
  parameter int     IMG_W        = DEF_IMG_W,
  parameter int     IMG_H        = DEF_IMG_H,
  parameter int     X_OFF        = DEF_X_OFF,
  parameter int     Y_OFF        = DEF_Y_OFF,
  parameter int     X_W          = 10,
  parameter int     Y_W          = 9,
  parameter int     ADDR_W       = DEF_ADDR_W,
  parameter int     RD_LATENCY   = 1,
  parameter color_t BORDER_COLOR = DEF_BORDER_COLOR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [X_W-1:0]    pixel_x,
  input  logic [Y_W-1:0]    pixel_y,
  input  logic              de_in,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [23:0]       rd_data,
  output color_t            color_out,
  output logic              de_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic              synced
);

  localparam int L = RD_LATENCY + 2;

  localparam logic [X_W:0]      X_LO     = (X_W+1)'(X_OFF);
  localparam logic [X_W:0]      X_HI     = (X_W+1)'(X_OFF + IMG_W);
  localparam logic [Y_W:0]      Y_LO     = (Y_W+1)'(Y_OFF);
  localparam logic [Y_W:0]      Y_HI     = (Y_W+1)'(Y_OFF + IMG_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  sync_state_t       state, state_next;
  logic              frame_start, synced_eff, in_win, new_line;
  logic [X_W:0]      x_ext, x_rel;
  logic [Y_W:0]      y_ext;
  logic [Y_W-1:0]    prev_y;
  logic [ADDR_W-1:0] row_base, row_base_eff;
  logic [3:0]        dly_in, dly_out;

  assign frame_start = (pixel_x == '0) && (pixel_y == '0);
  assign synced      = (state == ST_SYNC);
  assign synced_eff  = synced | frame_start;

  assign x_ext = {1'b0, pixel_x};
  assign y_ext = {1'b0, pixel_y};
  assign x_rel = x_ext - X_LO;

  assign in_win = de_in && synced_eff &&
                  (x_ext >= X_LO) && (x_ext < X_HI) &&
                  (y_ext >= Y_LO) && (y_ext < Y_HI);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_UNSYNC;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_UNSYNC: if (frame_start) state_next = ST_SYNC;
      ST_SYNC:   state_next = ST_SYNC;
    endcase
  end

  // The row base used this cycle already includes the line step, so the
  // first column of a new line gets the right address even when X_OFF is 0.
  assign new_line = (pixel_y != prev_y);

  always_comb begin
    row_base_eff = row_base;
    if (new_line) begin
      if (y_ext == Y_LO)
        row_base_eff = '0;
      else if ((y_ext > Y_LO) && (y_ext < Y_HI))
        row_base_eff = row_base + ROW_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_y   <= '0;
      row_base <= '0;
      rd_addr  <= '0;
      rd_en    <= 1'b0;
    end else begin
      prev_y   <= pixel_y;
      row_base <= row_base_eff;
      rd_en    <= in_win;
      if (in_win) rd_addr <= row_base_eff + ADDR_W'(x_rel);
    end
  end

  // Flags ride L-1 stages here; the output register below supplies the last.
  assign dly_in = {in_win, de_in, hs_in, vs_in};

  sync_delay #(
    .WIDTH (4),
    .DEPTH (L - 1)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (dly_in),
    .dout (dly_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      color_out <= BORDER_COLOR;
      de_out    <= 1'b0;
      hs_out    <= 1'b0;
      vs_out    <= 1'b0;
    end else begin
      color_out <= dly_out[3] ? rd_data : BORDER_COLOR;
      de_out    <= dly_out[2];
      hs_out    <= dly_out[1];
      vs_out    <= dly_out[0];
    end
  end

endmodule

// File: tb/tb_fb_pixel_fetch.sv
// tb/tb_fb_pixel_fetch.sv - randomized raster against a window/address reference model, two builds
module tb_fb_pixel_fetch;

  localparam int NW = 300 * 300;
  localparam int L0 = 3;
  localparam int L1 = 5;

  typedef struct packed {
    logic        win;
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] color;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  px;
  logic [8:0]  py;
  logic        de, hs, vs;

  logic [16:0] d0_rd_addr, d1_rd_addr;
  logic        d0_rd_en, d1_rd_en;
  logic [23:0] d0_color, d1_color;
  logic        d0_de, d0_hs, d0_vs, d0_synced;
  logic        d1_de, d1_hs, d1_vs, d1_synced;

  logic [23:0] mem [NW];
  logic [23:0] rd0;
  logic [23:0] p1 [3];
  wire  [23:0] rd1 = p1[2];

  exp_t        q0[$];
  exp_t        q1[$];
  int          n_total = 0;
  int          n_bad   = 0;
  bit          sync_m;
  logic [16:0] held0, held1;

  always #5 clk = ~clk;

  fb_pixel_fetch u_dut0 (
    .clk (clk), .rst (rst), .pixel_x (px), .pixel_y (py),
    .de_in (de), .hs_in (hs), .vs_in (vs),
    .rd_addr (d0_rd_addr), .rd_en (d0_rd_en), .rd_data (rd0),
    .color_out (d0_color), .de_out (d0_de), .hs_out (d0_hs), .vs_out (d0_vs),
    .synced (d0_synced)
  );

  fb_pixel_fetch #(
    .X_OFF (0), .Y_OFF (0), .RD_LATENCY (3)
  ) u_dut1 (
    .clk (clk), .rst (rst), .pixel_x (px), .pixel_y (py),
    .de_in (de), .hs_in (hs), .vs_in (vs),
    .rd_addr (d1_rd_addr), .rd_en (d1_rd_en), .rd_data (rd1),
    .color_out (d1_color), .de_out (d1_de), .hs_out (d1_hs), .vs_out (d1_vs),
    .synced (d1_synced)
  );

  function automatic logic [23:0] rdm(input logic [16:0] a);
    return (int'(a) < NW) ? mem[a] : 24'h0;
  endfunction

  // Memory port B: registered read, extra pipeline for the latency-3 build
  always @(posedge clk) begin
    rd0   <= rdm(d0_rd_addr);
    p1[0] <= rdm(d1_rd_addr);
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_win(input int x, input int y, input bit d, input bit seff,
                                   input int xo, input int yo);
    return d && seff && (x >= xo) && (x < xo + 300) && (y >= yo) && (y < yo + 300);
  endfunction

  task automatic prefill();
    exp_t z;
    z = '0;
    q0.delete();
    q1.delete();
    repeat (L0 - 1) q0.push_back(z);
    repeat (L1 - 1) q1.push_back(z);
  endtask

  task automatic do_reset(input int x, input int y);
    @(negedge clk);
    rst = 1'b1; px = 10'(x); py = 9'(y); de = 1'b1; hs = 1'b0; vs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_d0_addr",  d0_rd_addr, 0);
    check_val("rst_d0_en",    d0_rd_en, 0);
    check_val("rst_d0_color", d0_color, 0);
    check_val("rst_d0_dhv",   {d0_de, d0_hs, d0_vs}, 0);
    check_val("rst_d0_sync",  d0_synced, 0);
    check_val("rst_d1_addr",  d1_rd_addr, 0);
    check_val("rst_d1_color", d1_color, 0);
    check_val("rst_d1_sync",  d1_synced, 0);
    sync_m = 1'b0;
    held0  = '0;
    held1  = '0;
    prefill();
  endtask

  task automatic step(input int x, input int y, input bit d, input bit h, input bit v);
    exp_t e;
    bit   fs, seff, w0, w1;
    @(negedge clk);
    rst = 1'b0; px = 10'(x); py = 9'(y); de = d; hs = h; vs = v;
    fs     = (x == 0) && (y == 0);
    seff   = sync_m || fs;
    sync_m = seff;
    w0 = model_win(x, y, d, seff, 170, 90);
    w1 = model_win(x, y, d, seff, 0, 0);
    if (w0) held0 = 17'((y - 90) * 300 + (x - 170));
    if (w1) held1 = 17'(y * 300 + x);
    e.win = w0; e.de = d; e.hs = h; e.vs = v; e.color = w0 ? mem[held0] : 24'h0;
    q0.push_back(e);
    e.win = w1; e.color = w1 ? mem[held1] : 24'h0;
    q1.push_back(e);
    @(posedge clk);
    #1;
    check_val("d0_rd_en",   d0_rd_en, w0);
    check_val("d0_rd_addr", d0_rd_addr, held0);
    check_val("d0_synced",  d0_synced, sync_m);
    check_val("d1_rd_en",   d1_rd_en, w1);
    check_val("d1_rd_addr", d1_rd_addr, held1);
    check_val("d1_synced",  d1_synced, sync_m);
    e = q0.pop_front();
    check_val("d0_color", d0_color, e.color);
    check_val("d0_dhv",   {d0_de, d0_hs, d0_vs}, {e.de, e.hs, e.vs});
    e = q1.pop_front();
    check_val("d1_color", d1_color, e.color);
    check_val("d1_dhv",   {d1_de, d1_hs, d1_vs}, {e.de, e.hs, e.vs});
  endtask

  // Each line visits x=0, both window edges of both builds, plus random columns
  task automatic run_lines(input int y0, input int y1);
    int xs[16];
    int t;
    for (int y = y0; y < y1; y++) begin
      xs[0] = 0;   xs[1] = 1;   xs[2] = 169;  xs[3] = 170;
      xs[4] = 171; xs[5] = 299; xs[6] = 300;  xs[7] = 301;
      xs[8] = 468; xs[9] = 469; xs[10] = 470; xs[11] = 639;
      xs[12] = 799;
      for (int k = 13; k < 16; k++) xs[k] = int'($urandom_range(0, 799));
      for (int i = 0; i < 15; i++)
        for (int j = 0; j < 15 - i; j++)
          if (xs[j] > xs[j+1]) begin
            t = xs[j]; xs[j] = xs[j+1]; xs[j+1] = t;
          end
      for (int k = 0; k < 16; k++)
        step(xs[k], y,
             (xs[k] < 640) && ($urandom_range(0, 15) != 0),
             (xs[k] >= 656) && (xs[k] < 752),
             (y >= 395) && (y < 397));
    end
  endtask

  initial begin
    rst = 1'b1; px = '0; py = '0; de = 1'b0; hs = 1'b0; vs = 1'b0;
    sync_m = 1'b0; held0 = '0; held1 = '0;
    for (int i = 0; i < NW; i++) mem[i] = 24'($urandom);
    do_reset(5, 5);
    run_lines(0, 400);
    run_lines(0, 200);
    do_reset(300, 200);
    run_lines(200, 400);
    run_lines(0, 400);
    run_lines(0, 120);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
